// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges pipeline (A) and long-latency (B) results into one registered RF write per cycle.
// Optional retired-write counter output enabled by defining WB_RETIRE_CNT_EN.
module wb_arbiter #(
    parameter int DATA_W     = 64,
    parameter int ADDR_W     = 5,
    parameter int STARVE_MAX = 4
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              ExcStop,
    input  logic              A_Valid,
    output logic              A_Ready,
    input  logic              A_WriteEn,
    input  logic [ADDR_W-1:0] A_Addr,
    input  logic [DATA_W-1:0] A_Data,
    input  logic              B_Valid,
    output logic              B_Ready,
    input  logic [ADDR_W-1:0] B_Addr,
    input  logic [DATA_W-1:0] B_Data,
    output logic [DATA_W-1:0] RdWriteData,
    output logic [ADDR_W-1:0] RdWriteAddr,
    output logic              RdWriteEnable,
`ifdef WB_RETIRE_CNT_EN
    output logic [63:0]       RetireCount,
`endif
    output logic [3:0]        StarveCnt
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic a_starved;
    logic a_xfer;
    logic b_xfer;

    // B holds priority (older instruction) until A has waited STARVE_MAX cycles.
    always_comb begin
        a_starved = (StarveCnt == STARVE_LIM);
        A_Ready   = A_Valid && (!B_Valid || a_starved);
        B_Ready   = B_Valid && !A_Ready;
        a_xfer    = A_Valid && A_Ready;
        b_xfer    = B_Valid && B_Ready;
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            StarveCnt <= '0;
        end else if (a_xfer || ExcStop) begin
            StarveCnt <= '0;
        end else if (A_Valid && !A_Ready && !a_starved) begin
            StarveCnt <= StarveCnt + 4'd1;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            RdWriteEnable <= 1'b0;
            RdWriteAddr   <= '0;
            RdWriteData   <= '0;
        end else if (a_xfer) begin
            RdWriteEnable <= A_WriteEn && (A_Addr != '0) && !ExcStop;
            RdWriteAddr   <= A_Addr;
            RdWriteData   <= A_Data;
        end else if (b_xfer) begin
            RdWriteEnable <= (B_Addr != '0);
            RdWriteAddr   <= B_Addr;
            RdWriteData   <= B_Data;
        end else begin
            RdWriteEnable <= 1'b0;
        end
    end

`ifdef WB_RETIRE_CNT_EN
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            RetireCount <= '0;
        end else if (RdWriteEnable) begin
            RetireCount <= RetireCount + 64'd1;
        end
    end
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: driver runs a behavioural model and queues expectations,
// a negedge monitor pops and compares handshake, starvation count and register-file writes.
module tb_wb_arbiter;

    localparam int SMAX = 4;

    logic        Clk = 1'b0;
    logic        Rst = 1'b0;
    logic        ExcStop = 1'b0;
    logic        A_Valid = 1'b1;
    logic        A_Ready;
    logic        A_WriteEn = 1'b0;
    logic [4:0]  A_Addr = '0;
    logic [63:0] A_Data = '0;
    logic        B_Valid = 1'b1;
    logic        B_Ready;
    logic [4:0]  B_Addr = '0;
    logic [63:0] B_Data = '0;
    logic [63:0] RdWriteData;
    logic [4:0]  RdWriteAddr;
    logic        RdWriteEnable;
    logic [3:0]  StarveCnt;
`ifdef WB_RETIRE_CNT_EN
    logic [63:0] RetireCount;
`endif

    wb_arbiter #(.DATA_W(64), .ADDR_W(5), .STARVE_MAX(SMAX)) dut (
        .Clk(Clk), .Rst(Rst), .ExcStop(ExcStop),
        .A_Valid(A_Valid), .A_Ready(A_Ready), .A_WriteEn(A_WriteEn),
        .A_Addr(A_Addr), .A_Data(A_Data),
        .B_Valid(B_Valid), .B_Ready(B_Ready), .B_Addr(B_Addr), .B_Data(B_Data),
        .RdWriteData(RdWriteData), .RdWriteAddr(RdWriteAddr),
        .RdWriteEnable(RdWriteEnable),
`ifdef WB_RETIRE_CNT_EN
        .RetireCount(RetireCount),
`endif
        .StarveCnt(StarveCnt)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    typedef struct {
        logic [4:0]  addr;
        logic [63:0] data;
        int          due;
    } wr_t;

    typedef struct {
        bit chk_rdy;
        bit a_rdy;
        bit b_rdy;
        int starve;
    } hs_t;

    wr_t wr_q[$];
    hs_t hs_q[$];
    bit  rst_due[int];

    int n_cmp = 0;
    int n_bad = 0;

    // model state
    int m_starve = 0;
    bit last_ga = 1'b0;
    bit last_gb = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic drive(input bit rst, input bit av, input bit awe, input logic [4:0] aa,
                         input logic [63:0] ad, input bit bv, input logic [4:0] ba,
                         input logic [63:0] bd, input bit exc);
        hs_t h;
        wr_t w;
        bit  ga, gb;
        @(posedge Clk);
        #2;
        Rst = rst; A_Valid = av; A_WriteEn = awe; A_Addr = aa; A_Data = ad;
        B_Valid = bv; B_Addr = ba; B_Data = bd; ExcStop = exc;

        ga = rst && av && (!bv || m_starve >= SMAX);
        gb = rst && bv && !ga;
        h.chk_rdy = rst; h.a_rdy = ga; h.b_rdy = gb; h.starve = m_starve;
        hs_q.push_back(h);

        // B (older) is written before A in program order; at most one is granted anyway
        if (ga && awe && aa != 0 && !exc) begin
            w.addr = aa; w.data = ad; w.due = cyc + 1;
            wr_q.push_back(w);
        end
        if (gb && ba != 0) begin
            w.addr = ba; w.data = bd; w.due = cyc + 1;
            wr_q.push_back(w);
        end

        if (!rst || ga || exc) m_starve = 0;
        else if (av) m_starve = (m_starve + 1 > SMAX) ? SMAX : m_starve + 1;
        if (!rst) rst_due[cyc + 1] = 1'b1;
        last_ga = ga;
        last_gb = gb;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // monitor
    hs_t   mh;
    wr_t   mw;
    bit    exp_en;
    logic [63:0] exp_retire = '0;
    always @(negedge Clk) begin
        if (hs_q.size() > 0) begin
            mh = hs_q.pop_front();
            check("starve_cnt", StarveCnt, mh.starve);
            if (mh.chk_rdy) begin
                check("a_ready", A_Ready, mh.a_rdy);
                check("b_ready", B_Ready, mh.b_rdy);
            end
            exp_en = (wr_q.size() > 0) && (wr_q[0].due == cyc);
            check("wr_en", RdWriteEnable, exp_en);
            if (exp_en) begin
                mw = wr_q.pop_front();
                check("wr_addr", RdWriteAddr, mw.addr);
                check("wr_data", RdWriteData, mw.data);
            end
`ifdef WB_RETIRE_CNT_EN
            if (rst_due.exists(cyc)) exp_retire = '0;
            check("retire_cnt", RetireCount, exp_retire);
            if (exp_en) exp_retire = exp_retire + 64'd1;
`endif
        end
    end

    bit          ra_v = 1'b0, ra_we = 1'b0, rb_v = 1'b0, rexc;
    logic [4:0]  ra_a = '0, rb_a = '0;
    logic [63:0] ra_d = '0, rb_d = '0;

    task automatic random_phase(input int n);
        for (int i = 0; i < n; i++) begin
            if (!(ra_v && !last_ga)) begin
                ra_v  = ($urandom % 4) != 0;
                ra_we = ($urandom % 4) != 0;
                ra_a  = (($urandom % 8) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                ra_d  = {$urandom, $urandom};
            end
            if (!(rb_v && !last_gb)) begin
                rb_v = ($urandom % 2) != 0;
                rb_a = (($urandom % 8) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                rb_d = {$urandom, $urandom};
            end
            rexc = ($urandom % 10) == 0;
            drive(1, ra_v, ra_we, ra_a, ra_d, rb_v, rb_a, rb_d, rexc);
        end
    endtask

    int b_idx;
    bit a_done;

    initial begin
        // reset with both valid
        drive(0, 1, 1, 5, 64'h1234, 1, 6, 64'h55, 0);
        drive(0, 1, 1, 5, 64'h1234, 1, 6, 64'h55, 0);
        // release: B wins first, then A alone
        drive(1, 1, 1, 5, 64'h1234, 1, 6, 64'h55, 0);
        drive(1, 1, 1, 5, 64'h1234, 0, 0, 0, 0);
        // x0 and no-write
        drive(1, 1, 1, 0, 64'h77, 0, 0, 0, 0);
        drive(1, 1, 0, 3, 64'h88, 0, 0, 0, 0);
        // starvation: A held, B streaming
        b_idx = 0;
        a_done = 1'b0;
        for (int i = 0; i < 7; i++) begin
            drive(1, !a_done, 1, 12, 64'hA1, 1, 5'(13 + b_idx), 64'hB00 + 64'(b_idx), 0);
            if (last_ga) a_done = 1'b1;
            if (last_gb) b_idx++;
        end
        // flush: A killed, B survives
        drive(1, 1, 1, 7, 64'h7777, 0, 0, 0, 1);
        drive(1, 0, 0, 0, 0, 1, 9, 64'hAA, 1);
        // same rd on both ports
        drive(1, 1, 1, 10, 64'h1, 1, 10, 64'h2, 0);
        drive(1, 1, 1, 10, 64'h1, 0, 0, 0, 0);
        idle(2);

        random_phase(400);
        drive(0, 1, 1, 4, 64'hDEAD, 1, 8, 64'hBEEF, 0);
        ra_v = 1'b0;
        rb_v = 1'b0;
        random_phase(200);
        idle(4);

        @(negedge Clk);
        #1;
        check("pending_writes", 64'(wr_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
